// File: rtl/rv32i_types_pkg.sv
// Shared RV32I machine-mode types: recovery sequencer states, event kinds and
// exception cause codes.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    FLUSH    = 3'd2,
    CFLUSH   = 3'd3,
    REDIRECT = 3'd4
  } trap_state_t;

  typedef enum logic [1:0] {
    TK_EXC    = 2'd0,
    TK_INTR   = 2'd1,
    TK_RET    = 2'd2,
    TK_IFENCE = 2'd3
  } trap_kind_t;

  localparam logic [31:0] EXC_INSN_MISALIGNED  = 32'd0;
  localparam logic [31:0] EXC_INSN_FAULT       = 32'd1;
  localparam logic [31:0] EXC_ILLEGAL_INSN     = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT       = 32'd3;
  localparam logic [31:0] EXC_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] EXC_LOAD_FAULT       = 32'd5;
  localparam logic [31:0] EXC_STORE_MISALIGNED = 32'd6;
  localparam logic [31:0] EXC_STORE_FAULT      = 32'd7;
  localparam logic [31:0] EXC_ECALL_M          = 32'd11;

  // Only exceptions and interrupts write mcause/mtval/mepc.
  function automatic logic is_trap(input trap_kind_t kind);
    return (kind == TK_EXC) || (kind == TK_INTR);
  endfunction

endpackage

// File: rtl/trap_cause_encoder.sv
// Priority encoder for the ROB-head event: picks the single winning event and
// produces its mcause, mtval and kind.
module trap_cause_encoder
  import rv32i_types_pkg::*;
(
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        fault_l,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        mal_s,
  input  logic        intr,
  input  logic [3:0]  intr_cause,
  input  logic        ret,
  input  logic        ifence,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr_d,
  input  logic [31:0] badaddr_i,
  output logic        valid,
  output trap_kind_t  kind,
  output logic [31:0] cause,
  output logic [31:0] tval
);

  // Fixed-priority selection; lower-priority simultaneous events are dropped.
  always_comb begin
    valid = 1'b1;
    kind  = TK_EXC;
    cause = 32'd0;
    tval  = 32'd0;
    if (breakpoint) begin
      cause = EXC_BREAKPOINT;
      tval  = epc;
    end else if (fault_insn) begin
      cause = EXC_INSN_FAULT;
      tval  = badaddr_i;
    end else if (mal_insn) begin
      cause = EXC_INSN_MISALIGNED;
      tval  = badaddr_i;
    end else if (illegal_insn) begin
      cause = EXC_ILLEGAL_INSN;
    end else if (env_m) begin
      cause = EXC_ECALL_M;
    end else if (mal_l) begin
      cause = EXC_LOAD_MISALIGNED;
      tval  = badaddr_d;
    end else if (mal_s) begin
      cause = EXC_STORE_MISALIGNED;
      tval  = badaddr_d;
    end else if (fault_l) begin
      cause = EXC_LOAD_FAULT;
      tval  = badaddr_d;
    end else if (fault_s) begin
      cause = EXC_STORE_FAULT;
      tval  = badaddr_d;
    end else if (intr) begin
      kind  = TK_INTR;
      cause = {1'b1, 27'd0, intr_cause};
    end else if (ret) begin
      kind = TK_RET;
    end else if (ifence) begin
      kind = TK_IFENCE;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/ooo_trap_flush_sequencer.sv
// Commit-side recovery sequencer: freezes commit on a ROB-head event, drains,
// flushes stages (and caches for fence.i), then redirects fetch.
module ooo_trap_flush_sequencer
  import rv32i_types_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        fault_l,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        mal_s,
  input  logic        intr,
  input  logic [3:0]  intr_cause,
  input  logic        ret,
  input  logic        ifence,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr_d,
  input  logic [31:0] badaddr_i,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        d_mem_busy,
  input  logic        i_mem_busy,
  input  logic        busy_du,
  input  logic        busy_mu,
  input  logic        dflushed,
  input  logic        iflushed,
  output logic        pc_en,
  output logic        ex_comm_flush,
  output logic        ex_mem_flush,
  output logic        id_ex_flush,
  output logic        if_id_flush,
  output logic        ifence_flush,
  output logic        insert_priv_pc,
  output logic [31:0] priv_pc,
  output logic        intr_taken,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_tval,
  output logic [31:0] trap_epc,
  output logic        drain_timeout
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  trap_state_t state_r, next_s;
  trap_kind_t  kind_r, enc_kind_s;
  logic [7:0]  cnt_r;
  logic        event_s, busy_s, timeout_hit_s;
  logic [31:0] enc_cause_s, enc_tval_s, target_s, base_s;
  logic [31:0] cause_r, tval_r, epc_r, target_r;
  logic        stage_flush_r, ifence_flush_r, insert_r, intr_taken_r, drain_timeout_r;
  logic [31:0] priv_pc_r, trap_cause_r, trap_tval_r, trap_epc_r;

  trap_cause_encoder u_enc (
    .fault_insn   (fault_insn),
    .mal_insn     (mal_insn),
    .illegal_insn (illegal_insn),
    .breakpoint   (breakpoint),
    .env_m        (env_m),
    .fault_l      (fault_l),
    .mal_l        (mal_l),
    .fault_s      (fault_s),
    .mal_s        (mal_s),
    .intr         (intr),
    .intr_cause   (intr_cause),
    .ret          (ret),
    .ifence       (ifence),
    .epc          (epc),
    .badaddr_d    (badaddr_d),
    .badaddr_i    (badaddr_i),
    .valid        (event_s),
    .kind         (enc_kind_s),
    .cause        (enc_cause_s),
    .tval         (enc_tval_s)
  );

  // Redirect target; vectored mode offsets interrupts only.
  always_comb begin
    base_s   = {mtvec[31:2], 2'b00};
    target_s = base_s;
    case (enc_kind_s)
      TK_RET:    target_s = mepc;
      TK_IFENCE: target_s = epc + 32'd4;
      TK_INTR: begin
        if (mtvec[1:0] == 2'b01) begin
          target_s = base_s + {26'd0, enc_cause_s[3:0], 2'b00};
        end else begin
          target_s = base_s;
        end
      end
      default:   target_s = base_s;
    endcase
  end

  // Next-state logic and the combinational commit freeze.
  always_comb begin
    next_s        = state_r;
    timeout_hit_s = 1'b0;
    busy_s        = d_mem_busy | i_mem_busy | busy_du | busy_mu;
    pc_en         = (state_r == IDLE) && !event_s;
    case (state_r)
      IDLE: begin
        if (event_s) next_s = DRAIN;
        else         next_s = IDLE;
      end
      DRAIN: begin
        if (!busy_s) begin
          next_s = FLUSH;
        end else if (cnt_r == DRAIN_LAST) begin
          next_s        = FLUSH;
          timeout_hit_s = 1'b1;
        end else begin
          next_s = DRAIN;
        end
      end
      FLUSH: begin
        if (cnt_r == FLUSH_LAST) next_s = (kind_r == TK_IFENCE) ? CFLUSH : REDIRECT;
        else                     next_s = FLUSH;
      end
      CFLUSH: begin
        if (dflushed && iflushed) next_s = REDIRECT;
        else                      next_s = CFLUSH;
      end
      REDIRECT: next_s = IDLE;
      default:  next_s = IDLE;
    endcase
  end

  // State, capture and registered outputs; outputs are decoded from next_s so
  // they line up with the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r         <= IDLE;
      cnt_r           <= 8'd0;
      kind_r          <= TK_EXC;
      cause_r         <= 32'd0;
      tval_r          <= 32'd0;
      epc_r           <= 32'd0;
      target_r        <= 32'd0;
      stage_flush_r   <= 1'b0;
      ifence_flush_r  <= 1'b0;
      insert_r        <= 1'b0;
      intr_taken_r    <= 1'b0;
      drain_timeout_r <= 1'b0;
      priv_pc_r       <= 32'd0;
      trap_cause_r    <= 32'd0;
      trap_tval_r     <= 32'd0;
      trap_epc_r      <= 32'd0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) begin
        cnt_r <= 8'd0;
      end else if ((state_r == DRAIN) || (state_r == FLUSH)) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if ((state_r == IDLE) && event_s) begin
        kind_r   <= enc_kind_s;
        cause_r  <= enc_cause_s;
        tval_r   <= enc_tval_s;
        epc_r    <= epc;
        target_r <= target_s;
      end
      drain_timeout_r <= drain_timeout_r | timeout_hit_s;
      stage_flush_r   <= (next_s == FLUSH);
      ifence_flush_r  <= (next_s == CFLUSH);
      insert_r        <= (next_s == REDIRECT);
      intr_taken_r    <= (next_s == REDIRECT) && is_trap(kind_r);
      if (next_s == REDIRECT) begin
        priv_pc_r <= target_r;
        if (is_trap(kind_r)) begin
          trap_cause_r <= cause_r;
          trap_tval_r  <= tval_r;
          trap_epc_r   <= epc_r;
        end
      end
    end
  end

  assign ex_comm_flush  = stage_flush_r;
  assign ex_mem_flush   = stage_flush_r;
  assign id_ex_flush    = stage_flush_r;
  assign if_id_flush    = stage_flush_r;
  assign ifence_flush   = ifence_flush_r;
  assign insert_priv_pc = insert_r;
  assign priv_pc        = priv_pc_r;
  assign intr_taken     = intr_taken_r;
  assign trap_cause     = trap_cause_r;
  assign trap_tval      = trap_tval_r;
  assign trap_epc       = trap_epc_r;
  assign drain_timeout  = drain_timeout_r;

endmodule

// File: tb/tb_ooo_trap_flush_sequencer.sv
// Directed bench for ooo_trap_flush_sequencer; cycle 0 is the event cycle and
// every expected value below is worked out by hand from the recovery timeline.
module tb_ooo_trap_flush_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
  logic        fault_l, mal_l, fault_s, mal_s, intr, ret, ifence;
  logic [3:0]  intr_cause;
  logic [31:0] epc, badaddr_d, badaddr_i, mtvec, mepc;
  logic        d_mem_busy, i_mem_busy, busy_du, busy_mu, dflushed, iflushed;
  logic        pc_en, ex_comm_flush, ex_mem_flush, id_ex_flush, if_id_flush;
  logic        ifence_flush, insert_priv_pc, intr_taken, drain_timeout;
  logic [31:0] priv_pc, trap_cause, trap_tval, trap_epc;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 CLK = ~CLK;

  ooo_trap_flush_sequencer #(.FLUSH_CYCLES(2), .DRAIN_TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env_m(env_m), .fault_l(fault_l), .mal_l(mal_l),
    .fault_s(fault_s), .mal_s(mal_s), .intr(intr), .intr_cause(intr_cause),
    .ret(ret), .ifence(ifence), .epc(epc), .badaddr_d(badaddr_d),
    .badaddr_i(badaddr_i), .mtvec(mtvec), .mepc(mepc),
    .d_mem_busy(d_mem_busy), .i_mem_busy(i_mem_busy), .busy_du(busy_du),
    .busy_mu(busy_mu), .dflushed(dflushed), .iflushed(iflushed),
    .pc_en(pc_en), .ex_comm_flush(ex_comm_flush), .ex_mem_flush(ex_mem_flush),
    .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
    .ifence_flush(ifence_flush), .insert_priv_pc(insert_priv_pc),
    .priv_pc(priv_pc), .intr_taken(intr_taken), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .trap_epc(trap_epc), .drain_timeout(drain_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_events();
    {fault_insn, mal_insn, illegal_insn, breakpoint, env_m} = 5'd0;
    {fault_l, mal_l, fault_s, mal_s, intr, ret, ifence}     = 7'd0;
  endtask

  // Steps from the event cycle until insert_priv_pc; cyc = cycles elapsed.
  task automatic wait_redirect(input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      if (cyc == 0) clear_events();
      cyc++;
    end while (!insert_priv_pc && cyc < budget);
    check_val("redirect_seen", {31'd0, insert_priv_pc}, 32'd1);
  endtask

  logic [31:0] exp_cause [3] = '{32'd1, 32'd6, 32'd4};
  logic [31:0] exp_tval  [3] = '{32'h66, 32'h55, 32'h55};

  initial begin
    int  cyc;
    logic seen;
    RST = 1'b1;
    clear_events();
    intr_cause = 4'd0; epc = 32'd0; badaddr_d = 32'h55; badaddr_i = 32'h66;
    mtvec = 32'h1000; mepc = 32'd0;
    {d_mem_busy, i_mem_busy, busy_du, busy_mu, dflushed, iflushed} = 6'd0;

    // Reset, with an interrupt present on the last reset edge that must be lost.
    step();
    intr = 1'b1;
    step();
    RST = 1'b0;
    clear_events();
    #1;
    check_val("rst_pc_en", {31'd0, pc_en}, 32'd1);
    check_val("rst_insert", {31'd0, insert_priv_pc}, 32'd0);
    check_val("rst_priv_pc", priv_pc, 32'd0);
    check_val("rst_dto", {31'd0, drain_timeout}, 32'd0);
    check_val("rst_cause", trap_cause, 32'd0);
    step(); step();
    check_val("rst_evt_dropped", {31'd0, if_id_flush}, 32'd0);
    step();

    // Illegal instruction, minimum latency.
    illegal_insn = 1'b1; epc = 32'h200; mtvec = 32'h1000;
    #1;
    check_val("ill_pc_en_c0", {31'd0, pc_en}, 32'd0);
    step(); clear_events();
    check_val("ill_flush_c1", {31'd0, if_id_flush}, 32'd0);
    step();
    check_val("ill_flush_c2", {28'd0, ex_comm_flush, ex_mem_flush, id_ex_flush, if_id_flush}, 32'hF);
    step();
    check_val("ill_flush_c3", {28'd0, ex_comm_flush, ex_mem_flush, id_ex_flush, if_id_flush}, 32'hF);
    step();
    check_val("ill_insert_c4", {31'd0, insert_priv_pc}, 32'd1);
    check_val("ill_flush_c4", {31'd0, id_ex_flush}, 32'd0);
    check_val("ill_priv_pc", priv_pc, 32'h1000);
    check_val("ill_taken", {31'd0, intr_taken}, 32'd1);
    check_val("ill_cause", trap_cause, 32'd2);
    check_val("ill_tval", trap_tval, 32'd0);
    check_val("ill_epc", trap_epc, 32'h200);
    step();
    check_val("ill_insert_c5", {31'd0, insert_priv_pc}, 32'd0);
    check_val("ill_taken_c5", {31'd0, intr_taken}, 32'd0);
    check_val("ill_priv_pc_hold", priv_pc, 32'h1000);
    check_val("ill_pc_en_c5", {31'd0, pc_en}, 32'd1);

    // Vectored interrupt with d_mem_busy high for cycles 0..4 (DRAIN cycles 1..5).
    intr = 1'b1; intr_cause = 4'd11; mtvec = 32'h1001; epc = 32'h480; d_mem_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) clear_events();
    end
    d_mem_busy = 1'b0;
    check_val("intr_drain_c5", {31'd0, ex_comm_flush}, 32'd0);
    step();
    check_val("intr_flush_c6", {31'd0, ex_comm_flush}, 32'd1);
    step(); step();
    check_val("intr_insert_c8", {31'd0, insert_priv_pc}, 32'd1);
    check_val("intr_priv_pc", priv_pc, 32'h102C);
    check_val("intr_cause", trap_cause, 32'h8000000B);
    check_val("intr_tval", trap_tval, 32'd0);
    check_val("intr_epc", trap_epc, 32'h480);
    check_val("intr_taken", {31'd0, intr_taken}, 32'd1);
    step();

    // fence.i at the top of the address space; flush-done flags arrive apart.
    ifence = 1'b1; epc = 32'hFFFF_FFFC;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) clear_events();
    end
    check_val("ifn_cflush_c4", {31'd0, ifence_flush}, 32'd1);
    check_val("ifn_stage_c4", {31'd0, if_id_flush}, 32'd0);
    step(); step();
    dflushed = 1'b1;
    step(); step();
    check_val("ifn_cflush_c8", {31'd0, ifence_flush}, 32'd1);
    step();
    iflushed = 1'b1;
    check_val("ifn_cflush_c9", {31'd0, ifence_flush}, 32'd1);
    step();
    dflushed = 1'b0; iflushed = 1'b0;
    check_val("ifn_insert_c10", {31'd0, insert_priv_pc}, 32'd1);
    check_val("ifn_cflush_c10", {31'd0, ifence_flush}, 32'd0);
    check_val("ifn_priv_pc", priv_pc, 32'h0);
    check_val("ifn_taken", {31'd0, intr_taken}, 32'd0);
    check_val("ifn_cause_hold", trap_cause, 32'h8000000B);
    step();

    // Breakpoint beats load fault and interrupt; vectored mtvec uses base for exceptions.
    breakpoint = 1'b1; fault_l = 1'b1; intr = 1'b1; badaddr_d = 32'h44; epc = 32'h300;
    wait_redirect(20, cyc);
    check_val("pri_latency", cyc, 32'd4);
    check_val("pri_cause", trap_cause, 32'd3);
    check_val("pri_tval", trap_tval, 32'h300);
    check_val("pri_priv_pc", priv_pc, 32'h1000);
    step();

    // tval source selection: instruction fault, store misaligned, load misaligned over store fault.
    badaddr_d = 32'h55;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       fault_insn = 1'b1;
        1:       mal_s = 1'b1;
        default: begin mal_l = 1'b1; fault_s = 1'b1; end
      endcase
      wait_redirect(20, cyc);
      check_val($sformatf("tv%0d_cause", i), trap_cause, exp_cause[i]);
      check_val($sformatf("tv%0d_tval", i), trap_tval, exp_tval[i]);
      step();
    end

    // Stuck busy_du: 64 DRAIN cycles then forced progress.
    env_m = 1'b1; busy_du = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 1) clear_events();
    end
    check_val("dto_c64_flag", {31'd0, drain_timeout}, 32'd0);
    check_val("dto_c64_flush", {31'd0, if_id_flush}, 32'd0);
    step();
    check_val("dto_c65_flag", {31'd0, drain_timeout}, 32'd1);
    check_val("dto_c65_flush", {31'd0, ex_mem_flush}, 32'd1);
    busy_du = 1'b0;
    cyc = 0;
    while (!insert_priv_pc && cyc < 10) begin step(); cyc++; end
    check_val("dto_tail", cyc, 32'd2);
    check_val("dto_cause", trap_cause, 32'd11);
    check_val("dto_sticky", {31'd0, drain_timeout}, 32'd1);
    step();

    // mret aborted by reset during FLUSH, then a clean mret.
    mepc = 32'h80; ret = 1'b1;
    step(); clear_events();
    step();
    check_val("ret_flush_c2", {31'd0, id_ex_flush}, 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    check_val("abort_pc_en", {31'd0, pc_en}, 32'd1);
    check_val("abort_flush", {31'd0, id_ex_flush}, 32'd0);
    check_val("abort_dto", {31'd0, drain_timeout}, 32'd0);
    check_val("abort_priv_pc", priv_pc, 32'd0);
    seen = insert_priv_pc;
    for (int i = 0; i < 6; i++) begin step(); seen = seen | insert_priv_pc; end
    check_val("abort_no_redirect", {31'd0, seen}, 32'd0);
    ret = 1'b1;
    wait_redirect(20, cyc);
    check_val("ret_latency", cyc, 32'd4);
    check_val("ret_priv_pc", priv_pc, 32'h80);
    check_val("ret_taken", {31'd0, intr_taken}, 32'd0);
    check_val("ret_cause_hold", trap_cause, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
